alien_sprite_ram: RTL and testbench

- Palette-indexed sprite memory for one 50x50 alien image (2500 pixels).
- Each pixel is stored as a 5-bit palette index. A fixed 32-entry palette expands the index to 24-bit RGB ({R,G,B}, 8 bits each).
- Read by the enemy sprite drawing FSM at pixel-clock rate. A write port allows runtime sprite updates; normally it is tied off.

---
 rtl/alien_sprite_ram.sv | 76 +++++++
 tb/tb_alien_sprite_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alien_sprite_ram.sv
// Palette-indexed sprite store for one 50x50 alien image: a DEPTH x IDX_W index
// array with a registered read port, a guarded write port and a fixed 32-colour palette.
module alien_sprite_ram #(
  parameter int DEPTH     = 2500,
  parameter int IDX_W     = 5,
  parameter int WADDR_W   = 19,
  parameter int RADDR_W   = 24,
  parameter     INIT_FILE = ""
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [IDX_W-1:0]   data_in,
  input  logic [WADDR_W-1:0] write_address,
  input  logic [RADDR_W-1:0] read_address,
  input  logic               we,
  output logic [23:0]        data_out
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam logic [WADDR_W-1:0] WR_DEPTH = WADDR_W'(DEPTH);
  localparam logic [RADDR_W-1:0] RD_DEPTH = RADDR_W'(DEPTH);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             wr_en;

  // Elaboration-time image contents; the array is deliberately outside the reset domain.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  function automatic logic [23:0] palette(input logic [IDX_W-1:0] idx);
    logic [23:0] rgb;
    case (idx)
      IDX_W'(0): rgb = 24'h000000;
      IDX_W'(1): rgb = 24'hFFFFFF;
      IDX_W'(2): rgb = 24'h00FF00;
      IDX_W'(3): rgb = 24'hFF0000;
      IDX_W'(4): rgb = 24'h0000FF;
      IDX_W'(5): rgb = 24'hFFFF00;
      IDX_W'(6): rgb = 24'h00FFFF;
      IDX_W'(7): rgb = 24'hFF00FF;
      default:   rgb = {3{idx[4:0], 3'b000}};
    endcase
    return rgb;
  endfunction

  // Range checks use the full port width so high address bits cannot alias into the array.
  always_comb begin
    wr_en   = we && Reset_n && (write_address < WR_DEPTH);
    valid_d = (read_address < RD_DEPTH);
    idx_d   = valid_d ? mem_q[read_address[AW-1:0]] : '0;
  end

  // NOTE: the storage array has no reset branch so it maps onto block RAM and
  // keeps its contents across Reset_n; only the read pipeline registers are cleared.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[write_address[AW-1:0]] <= data_in;
  end

  // NOTE: non-blocking assignments here make the read sample the pre-write array
  // contents, which is what gives read-first behaviour on a same-address collision.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = valid_q ? palette(idx_q) : 24'h000000;

endmodule

// File: tb/tb_alien_sprite_ram.sv
// Directed bench for alien_sprite_ram: reset, write/read, bounds, read-first
// collisions, streaming and asynchronous reset during a stream.
module tb_alien_sprite_ram;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  data_in;
  logic [18:0] write_address;
  logic [23:0] read_address;
  logic        we;
  logic [23:0] data_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  alien_sprite_ram dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .data_in       (data_in),
    .write_address (write_address),
    .read_address  (read_address),
    .we            (we),
    .data_out      (data_out)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] exp_rgb(input int idx);
    case (idx)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'h00FF00;
      3: return 24'hFF0000;
      4: return 24'h0000FF;
      5: return 24'hFFFF00;
      6: return 24'h00FFFF;
      7: return 24'hFF00FF;
      8: return 24'h404040;
      20: return 24'hA0A0A0;
      31: return 24'hF8F8F8;
      default: return 24'h0BAD00;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_px(input int addr, input int idx);
    we = 1'b1; write_address = 19'(addr); data_in = 5'(idx);
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; we = 1'b0; data_in = '0; write_address = '0; read_address = '0;
    tick(); tick();
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL reset_hold: got %h expected 000000", data_out);
    end
    Reset_n = 1'b1;
    tick();
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL reset_first_read: got %h expected 000000", data_out);
    end
  endtask

  task automatic test_write_read();
    write_px(10, 2);
    read_address = 24'd10;
    tick();
    vec_cnt++;
    if (data_out !== 24'h00FF00) begin
      err_cnt++; $display("FAIL wr_rd_idx2: got %h expected 00FF00", data_out);
    end
    write_px(10, 20);
    read_address = 24'd10;
    tick();
    vec_cnt++;
    if (data_out !== 24'hA0A0A0) begin
      err_cnt++; $display("FAIL wr_rd_idx20: got %h expected A0A0A0", data_out);
    end
    write_px(100, 8);
    write_px(101, 31);
    read_address = 24'd100;
    tick();
    vec_cnt++;
    if (data_out !== exp_rgb(8)) begin
      err_cnt++; $display("FAIL grey_idx8: got %h expected %h", data_out, exp_rgb(8));
    end
    read_address = 24'd101;
    tick();
    vec_cnt++;
    if (data_out !== exp_rgb(31)) begin
      err_cnt++; $display("FAIL grey_idx31: got %h expected %h", data_out, exp_rgb(31));
    end
  endtask

  task automatic test_bounds();
    write_px(2499, 6);
    write_px(2500, 3);
    write_px(4096 + 2499, 3);
    read_address = 24'd2499;
    tick();
    vec_cnt++;
    if (data_out !== 24'h00FFFF) begin
      err_cnt++; $display("FAIL oob_write_dropped: got %h expected 00FFFF", data_out);
    end
    read_address = 24'd2500;
    tick();
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL rd_2500: got %h expected 000000", data_out);
    end
    read_address = 24'hFFFFFF;
    tick();
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL rd_ffffff: got %h expected 000000", data_out);
    end
    read_address = 24'd4096 + 24'd10;
    tick();
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL rd_alias_4106: got %h expected 000000", data_out);
    end
  endtask

  task automatic test_read_during_write();
    write_px(5, 1);
    we = 1'b1; data_in = 5'd4; write_address = 19'd5; read_address = 24'd5;
    tick();
    we = 1'b0;
    vec_cnt++;
    if (data_out !== 24'hFFFFFF) begin
      err_cnt++; $display("FAIL rdw_old_data: got %h expected FFFFFF", data_out);
    end
    tick();
    vec_cnt++;
    if (data_out !== 24'h0000FF) begin
      err_cnt++; $display("FAIL rdw_new_data: got %h expected 0000FF", data_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 50; i++) write_px(i, i % 8);
    for (int i = 0; i < 50; i++) begin
      read_address = 24'(i);
      tick();
      vec_cnt++;
      if (data_out !== exp_rgb(i % 8)) begin
        err_cnt++;
        $display("FAIL stream_addr%0d: got %h expected %h", i, data_out, exp_rgb(i % 8));
      end
    end
  endtask

  task automatic test_mid_reset();
    read_address = 24'd1;
    tick();
    vec_cnt++;
    if (data_out !== 24'hFFFFFF) begin
      err_cnt++; $display("FAIL pre_reset_read: got %h expected FFFFFF", data_out);
    end
    read_address = 24'd3;
    #2 Reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL async_reset_clear: got %h expected 000000", data_out);
    end
    we = 1'b1; write_address = 19'd10; data_in = 5'd31;
    tick();
    we = 1'b0;
    vec_cnt++;
    if (data_out !== 24'h000000) begin
      err_cnt++; $display("FAIL reset_held_output: got %h expected 000000", data_out);
    end
    Reset_n = 1'b1;
    read_address = 24'd10;
    tick();
    vec_cnt++;
    if (data_out !== 24'h00FF00) begin
      err_cnt++; $display("FAIL post_reset_addr10: got %h expected 00FF00", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bounds();
    test_read_during_write();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
